seq_detect_prog: RTL
====================

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter MAX_LEN, default 8: longest supported pattern in bits (>=2).
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cfg_load  input  1  one-cycle pulse; latch cfg_pattern, cfg_len, cfg_overlap.
REQ-006 cfg_pattern  input  MAX_LEN  pattern bits; bit cfg_len-1 = first serial bit, bit 0 = last.
REQ-007 cfg_len  input  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
REQ-008 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-009 valid  input  1  qualifies the serial bit on a; a is ignored when valid=0.
REQ-010 a  input  1  serial data bit.
REQ-011 clr_cnt  input  1  one-cycle pulse; clears match_cnt and cnt_sat.
REQ-012 detected  output  1  registered one-cycle match pulse.
REQ-013 match_cnt  output  CNT_W  saturating count of matches.
REQ-014 cnt_sat  output  1  sticky; set when match_cnt reaches all-ones.
REQ-015 cfg_err  output  1  registered one-cycle pulse on an illegal cfg_len at cfg_load.
REQ-016 armed  output  1  high in ARMED state.

Function
REQ-017 Control FSM states: UNCFG, FILL, ARMED; registered state, combinational next-state.
REQ-018 UNCFG: valid bits ignored; cfg_load with legal cfg_len -> FILL; illegal -> stay UNCFG, pulse cfg_err.
REQ-019 FILL: each valid bit shifts into history hist <= {hist[MAX_LEN-2:0], a} and increments fill counter; -> ARMED on the valid bit that makes fill = len-1.
REQ-020 ARMED: on a valid bit, match = ({hist, a} low len bits == pattern low len bits); no match -> stay ARMED.
REQ-021 Match: detected=1 the cycle after the edge sampling the final bit; match_cnt increments at that same edge.
REQ-022 Overlap=1 after match: stay ARMED; history retained, so a trailing prefix can start the next match.
REQ-023 Overlap=0 after match: fill counter cleared, -> FILL (ARMED if len=1); no bit of a matched sequence reused.
REQ-024 len=1: FILL bypassed; legal cfg_load goes directly to ARMED.
REQ-025 cfg_load in any state: history and fill cleared, new config latched; match_cnt untouched; illegal cfg_len -> UNCFG plus cfg_err.
REQ-026 cfg_load and valid in the same cycle: cfg_load wins; that bit is dropped.
REQ-027 valid=0: history, fill and state hold; detected=0 next cycle.
REQ-028 match_cnt saturates at 2^CNT_W-1; cnt_sat sets on reaching it; further matches still pulse detected.
REQ-029 clr_cnt together with a match: clear wins, match_cnt=0 next cycle; detected still pulses.
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 rst_n low: state=UNCFG, history, fill, latched config, match_cnt=0; detected, cnt_sat, cfg_err, armed = 0.
REQ-032 Reset asserts asynchronously mid-operation; first active edge after rst_n release behaves as UNCFG.

Structure
REQ-033 Shared package seq_detect_pkg: FSM state enum, default MAX_LEN/CNT_W constants.
REQ-034 One sub-module, sat_counter (CNT_W-wide, inc/clr, clr priority, sat flag), used for match_cnt.

Verification
REQ-035 Load 110011 len 6 overlap=1, stream 0011_0101_1001_1001_1010_1000 -> detected after bits 12 and 16 (0-based), match_cnt=2.
REQ-036 Same stream, overlap=0 -> detected only after bit 12, match_cnt=1.
REQ-037 Load 1010 len 4, stream 1010100: overlap=1 -> 2 pulses; overlap=0 -> 1 pulse.
REQ-038 cfg_len=0 or MAX_LEN+1 -> cfg_err pulse, armed=0, no detection on any stream.
REQ-039 CNT_W=2, pattern 1 len 1, five valid 1s -> match_cnt 1,2,3,3,3; cnt_sat set at 3; clr_cnt -> 0.
REQ-040 rst_n pulsed low mid-pattern, then full reload -> all outputs 0, state UNCFG until cfg_load.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int unsigned DefaultMaxLen = 8;
    localparam int unsigned DefaultCntW   = 8;

    typedef enum logic [1:0] {
        StUncfg,
        StFill,
        StArmed
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment) and a sticky
// flag that sets on the edge the count reaches all-ones.
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sat_q, sat_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntMax) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: run-time pattern/length/overlap config, a
// registered match pulse and a saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = DefaultMaxLen,
    parameter int unsigned CNT_W   = DefaultCntW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_load_i,
    input  logic [MAX_LEN-1:0]           cfg_pattern_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len_i,
    input  logic                         cfg_overlap_i,
    input  logic                         valid_i,
    input  logic                         a_i,
    input  logic                         clr_cnt_i,
    output logic                         detected_o,
    output logic [CNT_W-1:0]             match_cnt_o,
    output logic                         cnt_sat_o,
    output logic                         cfg_err_o,
    output logic                         armed_o
);

    localparam int unsigned     LenW   = $clog2(MAX_LEN + 1);
    localparam logic [LenW-1:0] LenMax = LenW'(MAX_LEN);
    localparam logic [LenW-1:0] LenOne = LenW'(1);

    state_e             state_q, state_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LenW-1:0]    fill_q, fill_d, len_q, len_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic               det_q, det_d;
    logic               err_q, err_d;
    logic [MAX_LEN-1:0] window, len_mask;
    logic               cfg_legal, match, cnt_inc;

    // Newest bit sits at bit 0, so the low len bits line up with the pattern's low bits.
    assign window    = {hist_q, a_i};
    assign len_mask  = ~({MAX_LEN{1'b1}} << len_q);
    assign match     = ((window ^ pat_q) & len_mask) == '0;
    assign cfg_legal = (cfg_len_i != '0) && (cfg_len_i <= LenMax);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        len_d   = len_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        det_d   = 1'b0;
        err_d   = 1'b0;
        cnt_inc = 1'b0;

        if (cfg_load_i) begin
            hist_d = '0;
            fill_d = '0;
            if (cfg_legal) begin
                pat_d   = cfg_pattern_i;
                len_d   = cfg_len_i;
                ovl_d   = cfg_overlap_i;
                state_d = (cfg_len_i == LenOne) ? StArmed : StFill;
            end else begin
                state_d = StUncfg;
                err_d   = 1'b1;
            end
        end else if (valid_i) begin
            unique case (state_q)
                StFill: begin
                    hist_d = window[MAX_LEN-2:0];
                    fill_d = fill_q + LenOne;
                    if (fill_d == len_q - LenOne) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    hist_d = window[MAX_LEN-2:0];
                    if (match) begin
                        det_d   = 1'b1;
                        cnt_inc = 1'b1;
                        // Non-overlapping: refill len-1 fresh bits before comparing again.
                        if (!ovl_q) begin
                            fill_d  = '0;
                            state_d = (len_q == LenOne) ? StArmed : StFill;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StUncfg;
            hist_q  <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            det_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            det_q   <= det_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (cnt_inc),
        .clr_i (clr_cnt_i),
        .cnt_o (match_cnt_o),
        .sat_o (cnt_sat_o)
    );

    assign detected_o = det_q;
    assign cfg_err_o  = err_q;
    assign armed_o    = (state_q == StArmed);

endmodule
